// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command issuer
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [2:0] {
        OP_NEG    = 3'd0,
        OP_INC    = 3'd1,
        OP_ADD    = 3'd2,
        OP_ADDSHR = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_PACK   = 3'd6,
        OP_ZERO   = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e          opc;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             cin;
        logic             chain;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - power-of-two command queue with occupancy level
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_cmd_t               push_data,
    input  logic                   pop,
    output alu_cmd_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Fullness alone gates pushes, so a pop on the same edge never frees a slot early
    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, drives the ALU and returns captured results
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_opc,
    input  logic [ALU_W-1:0]       cmd_a,
    input  logic [ALU_W-1:0]       cmd_b,
    input  logic                   cmd_cin,
    input  logic                   cmd_chain,
    output logic [ALU_W-1:0]       alu_inA,
    output logic [ALU_W-1:0]       alu_inB,
    output logic                   alu_inC,
    output logic [2:0]             alu_opc,
    input  logic [ALU_W-1:0]       alu_outW,
    input  logic                   alu_zer,
    input  logic                   alu_neg,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ALU_W-1:0]       rsp_data,
    output logic                   rsp_zer,
    output logic                   rsp_neg,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy
);

    issuer_state_e    state;
    issuer_state_e    state_next;
    alu_cmd_t         new_cmd;
    alu_cmd_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;
    logic [ALU_W-1:0] last_result;

    assign new_cmd = '{opc: alu_op_e'(cmd_opc), a: cmd_a, b: cmd_b, cin: cmd_cin, chain: cmd_chain};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (new_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    pop        = !fifo_empty;
                    state_next = fifo_empty ? IDLE : EXEC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // last_result follows every capture, whether or not the response has been taken yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_inA     <= '0;
            alu_inB     <= '0;
            alu_inC     <= 1'b0;
            alu_opc     <= OP_ZERO;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_zer     <= 1'b0;
            rsp_neg     <= 1'b0;
            last_result <= '0;
        end else begin
            if (pop) begin
                alu_inA <= head.chain ? last_result : head.a;
                alu_inB <= head.b;
                alu_inC <= head.cin;
                alu_opc <= head.opc;
            end
            if (capture) begin
                rsp_data    <= alu_outW;
                rsp_zer     <= alu_zer;
                rsp_neg     <= alu_neg;
                last_result <= alu_outW;
                rsp_valid   <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
